vga_pattern_sequencer: RTL and testbench

Selects which of four full-screen test-pattern generators drives the VGA RGB565 pixel bus, and changes the selection only on frame boundaries so a switch never tears mid-frame. Sits between the pattern generators (each registered, one cycle from pix_x/pix_y to data, 0 outside the visible area) and the VGA timing/output stage. The selection advances on a single-cycle key pulse, or automatically every HOLD_FRAMES frames when auto mode is enabled.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_frame_tick.sv | 54 +++++
 rtl/vga_pattern_sequencer.sv | 108 ++++++++++
 tb/tb_vga_pattern_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel/data widths, RGB565 colours, pattern count,
// request-latch state type and a helper for sizing the frame counter.
package vga_pkg;

    localparam int              PIX_W       = 10;
    localparam logic [PIX_W-1:0] PIX_INVALID = 10'h3ff;
    localparam int              DATA_W      = 16;

    localparam logic [DATA_W-1:0] RGB_RED   = 16'hF800;
    localparam logic [DATA_W-1:0] RGB_GREEN = 16'h07E0;
    localparam logic [DATA_W-1:0] RGB_BLUE  = 16'h001F;
    localparam logic [DATA_W-1:0] RGB_WHITE = 16'hFFFF;
    localparam logic [DATA_W-1:0] RGB_BLACK = 16'h0000;

    localparam int NUM_PAT = 4;
    localparam int SEL_W   = 2;

    // Pending-advance latch: IDLE = nothing requested, PEND = advance at next frame start
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } req_state_t;

    // Frame counter width: clog2 of the hold length, never below one bit
    function automatic int cnt_width(input int hold);
        int w;
        w = $clog2(hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Frame-start detection, registered frame_start pulse and the auto-advance
// frame counter. The counter only moves on the frame-start cycle.
module vga_frame_tick
    import vga_pkg::*;
#(
    parameter int HOLD_FRAMES = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] i_pix_x,
    input  logic [PIX_W-1:0] i_pix_y,
    input  logic             i_auto_en,
    input  logic             i_advance,
    output logic             o_fs,
    output logic             o_auto_expire,
    output logic             o_frame_start
);

    localparam int               CNT_W    = cnt_width(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_FRAMES - 1);

    logic             w_fs;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_frame_start;

    // Pixel (0,0) is presented exactly once per frame
    assign w_fs          = (i_pix_x == '0) && (i_pix_y == '0);
    assign o_fs          = w_fs;
    assign o_auto_expire = i_auto_en && (r_frame_cnt == CNT_LAST);
    assign o_frame_start = r_frame_start;

    // frame_start lines up with the source data for pixel (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_fs;
        end
    end

    // Count frames shown with the current pattern; restart on advance or when auto is off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_fs) begin
            if (i_advance || !i_auto_en) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Chooses one of four test-pattern sources for the RGB565 pixel bus. The
// selection only changes on frame start so a switch never tears mid-frame.
module vga_pattern_sequencer
    import vga_pkg::*;
#(
    parameter int HOLD_FRAMES = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PIX_W-1:0]  i_pix_x,
    input  logic [PIX_W-1:0]  i_pix_y,
    input  logic              i_key_next,
    input  logic              i_auto_en,
    input  logic [DATA_W-1:0] i_src0_data,
    input  logic [DATA_W-1:0] i_src1_data,
    input  logic [DATA_W-1:0] i_src2_data,
    input  logic [DATA_W-1:0] i_src3_data,
    output logic [DATA_W-1:0] o_pix_data,
    output logic [SEL_W-1:0]  o_pat_sel,
    output logic              o_frame_start
);

    req_state_t        r_state;
    req_state_t        w_state_next;
    logic              w_fs;
    logic              w_auto_expire;
    logic              w_advance;
    logic              w_vis;
    logic              r_vis_d;
    logic [SEL_W-1:0]  r_pat_sel;
    logic [DATA_W-1:0] r_pix_data;
    logic [DATA_W-1:0] w_src [NUM_PAT];

    assign w_src[0] = i_src0_data;
    assign w_src[1] = i_src1_data;
    assign w_src[2] = i_src2_data;
    assign w_src[3] = i_src3_data;

    vga_frame_tick #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_frame_tick (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pix_x       (i_pix_x),
        .i_pix_y       (i_pix_y),
        .i_auto_en     (i_auto_en),
        .i_advance     (w_advance),
        .o_fs          (w_fs),
        .o_auto_expire (w_auto_expire),
        .o_frame_start (o_frame_start)
    );

    // A latched request, a key on the frame-start cycle itself and an auto
    // expiry all collapse into a single advance
    assign w_advance = w_fs && ((r_state == PEND) || i_key_next || w_auto_expire);
    assign w_vis     = (i_pix_x != PIX_INVALID) && (i_pix_y != PIX_INVALID);

    // Request latch: hold a mid-frame key until the next frame start
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_key_next && !w_fs) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_advance) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step the pattern on advance; the 2-bit counter wraps 3 -> 0 naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat_sel <= '0;
        end else if (w_advance) begin
            r_pat_sel <= r_pat_sel + SEL_W'(1);
        end
    end

    // Delay visibility one cycle to match the registered sources, then mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vis_d    <= 1'b0;
            r_pix_data <= '0;
        end else begin
            r_vis_d    <= w_vis;
            r_pix_data <= r_vis_d ? w_src[r_pat_sel] : '0;
        end
    end

    assign o_pix_data = r_pix_data;
    assign o_pat_sel  = r_pat_sel;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer on a small synthetic frame. Per-frame
// vectors give key/auto stimulus and the pattern expected for that frame;
// every pixel pushes its expected output into a scoreboard that is popped
// two cycles later.
module tb_vga_pattern_sequencer;
    import vga_pkg::*;

    localparam int HOLD   = 2;
    localparam int VIS_W  = 8;
    localparam int VIS_H  = 6;
    localparam int HBLANK = 2;
    localparam int VBLANK = 2;
    localparam int NVEC   = 21;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PIX_W-1:0]  i_pix_x = PIX_INVALID;
    logic [PIX_W-1:0]  i_pix_y = PIX_INVALID;
    logic              i_key_next = 1'b0;
    logic              i_auto_en = 1'b0;
    logic [DATA_W-1:0] i_src0_data = RGB_RED;
    logic [DATA_W-1:0] i_src1_data = RGB_GREEN;
    logic [DATA_W-1:0] i_src2_data = RGB_BLUE;
    logic [DATA_W-1:0] i_src3_data = RGB_WHITE;
    logic [DATA_W-1:0] o_pix_data;
    logic [SEL_W-1:0]  o_pat_sel;
    logic              o_frame_start;

    always #5 clk = ~clk;

    vga_pattern_sequencer #(
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pix_x       (i_pix_x),
        .i_pix_y       (i_pix_y),
        .i_key_next    (i_key_next),
        .i_auto_en     (i_auto_en),
        .i_src0_data   (i_src0_data),
        .i_src1_data   (i_src1_data),
        .i_src2_data   (i_src2_data),
        .i_src3_data   (i_src3_data),
        .o_pix_data    (o_pix_data),
        .o_pat_sel     (o_pat_sel),
        .o_frame_start (o_frame_start)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        logic       auto_en;
        int         n_keys;
        logic       key_fs;
        logic [1:0] exp_pat;
    } frame_vec_t;

    sb_t         sb_q[$];
    sb_t         chk_e;
    frame_vec_t  vecs [NVEC];
    logic [15:0] colours [NUM_PAT];
    logic [1:0]  cur_pat = 2'd0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard consumer: compare each pixel two cycles after it was driven
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                chk_e = sb_q.pop_front();
                if (chk_e.due != cyc) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_late: entry due %0d checked at %0d", chk_e.due, cyc);
                end else begin
                    check("pix_data", 32'(o_pix_data), 32'(chk_e.data));
                end
            end
        end
    end

    task automatic drive_pix(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y, input logic key);
        sb_t e;
        i_pix_x    = x;
        i_pix_y    = y;
        i_key_next = key;
        e.due  = cyc + 2;
        e.data = (x != PIX_INVALID && y != PIX_INVALID) ? colours[cur_pat] : 16'h0000;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One frame: (0,0) first, keys pulsed at row 0 columns 2,4,6; rows < VIS_H = partial frame
    task automatic run_frame(input logic auto_en, input int n_keys, input logic key_fs,
                             input logic [1:0] exp_pat, input int rows);
        logic [PIX_W-1:0] x;
        logic             key;
        cur_pat   = exp_pat;
        i_auto_en = auto_en;
        drive_pix(10'd0, 10'd0, key_fs);
        check("pat_sel_at_fs", 32'(o_pat_sel), 32'(exp_pat));
        check("frame_start_hi", 32'(o_frame_start), 32'd1);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < VIS_W + HBLANK; c++) begin
                if (r == 0 && c == 0) continue;
                key = (r == 0) && (c >= 2) && (c % 2 == 0) && (c / 2 <= n_keys);
                x   = (c < VIS_W) ? 10'(c) : PIX_INVALID;
                drive_pix(x, 10'(r), key);
                if (r == 0 && c == 1) begin
                    check("frame_start_lo", 32'(o_frame_start), 32'd0);
                end
            end
        end
        if (rows == VIS_H) begin
            for (int r = 0; r < VBLANK; r++) begin
                for (int c = 0; c < VIS_W + HBLANK; c++) begin
                    drive_pix(10'(c), PIX_INVALID, 1'b0);
                end
            end
        end
        check("pat_sel_hold", 32'(o_pat_sel), 32'(exp_pat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        colours[0] = RGB_RED;
        colours[1] = RGB_GREEN;
        colours[2] = RGB_BLUE;
        colours[3] = RGB_WHITE;

        // auto_en, mid-frame keys, key at fs, pattern expected for the frame
        vecs[0]  = '{1'b0, 3, 1'b0, 2'd0};  // three presses collapse into one pending advance
        vecs[1]  = '{1'b0, 0, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 0, 1'b0, 2'd1};  // exactly one advance
        vecs[3]  = '{1'b0, 0, 1'b1, 2'd2};  // key on the fs cycle advances immediately
        vecs[4]  = '{1'b0, 0, 1'b0, 2'd2};
        vecs[5]  = '{1'b0, 2, 1'b1, 2'd3};
        vecs[6]  = '{1'b0, 0, 1'b0, 2'd0};  // wrap 3 -> 0 by key
        vecs[7]  = '{1'b1, 0, 1'b0, 2'd0};  // auto, hold 2 frames
        vecs[8]  = '{1'b1, 0, 1'b0, 2'd1};
        vecs[9]  = '{1'b1, 0, 1'b0, 2'd1};
        vecs[10] = '{1'b1, 0, 1'b0, 2'd2};
        vecs[11] = '{1'b1, 0, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 0, 1'b0, 2'd3};
        vecs[13] = '{1'b1, 0, 1'b0, 2'd3};
        vecs[14] = '{1'b1, 0, 1'b0, 2'd0};
        vecs[15] = '{1'b1, 1, 1'b0, 2'd0};  // key pending while auto about to expire
        vecs[16] = '{1'b1, 0, 1'b0, 2'd1};  // key + expiry: single advance
        vecs[17] = '{1'b1, 0, 1'b0, 2'd1};
        vecs[18] = '{1'b0, 0, 1'b0, 2'd1};  // auto off at fs: no expiry, counter cleared
        vecs[19] = '{1'b1, 0, 1'b0, 2'd1};
        vecs[20] = '{1'b1, 0, 1'b0, 2'd2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_data", 32'(o_pix_data), 32'd0);
        check("rst_pat_sel", 32'(o_pat_sel), 32'd0);
        check("rst_frame_start", 32'(o_frame_start), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_frame(vecs[i].auto_en, vecs[i].n_keys, vecs[i].key_fs, vecs[i].exp_pat, VIS_H);
        end

        // Mid-frame reset while a request is pending on pattern 2
        run_frame(1'b0, 1, 1'b0, 2'd2, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_pix_data", 32'(o_pix_data), 32'd0);
        check("midrst_pat_sel", 32'(o_pat_sel), 32'd0);
        check("midrst_frame_start", 32'(o_frame_start), 32'd0);
        sb_q.delete();
        i_pix_x    = PIX_INVALID;
        i_pix_y    = PIX_INVALID;
        i_key_next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0, 0, 1'b0, 2'd0, VIS_H);  // pending request was discarded
        run_frame(1'b0, 0, 1'b0, 2'd0, VIS_H);
        run_frame(1'b0, 0, 1'b1, 2'd1, VIS_H);

        i_pix_x = PIX_INVALID;
        i_pix_y = PIX_INVALID;
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
